// File: rtl/eth_std_peripheral_irq_ctrl_if.sv
// Avalon-MM slave register bus of the peripheral interrupt controller.
// Read latency is one cycle: readdata is registered from the sampled address.
interface eth_std_peripheral_irq_ctrl_if;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect, write_n, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write_n, address, writedata,
        output readdata
    );
endinterface

// File: rtl/eth_std_peripheral_irq_ctrl.sv
// Peripheral interrupt controller: per-source sync, edge/level pending, mask, priority id, registered irq.
// Optional interrupt coalescing (threshold/holdoff) is built only when IRQ_CTRL_COALESCE_EN is defined.
module eth_std_peripheral_irq_ctrl #(
    parameter int          NUM_SRC  = 8,
    parameter logic [15:0] EDGE_RST = 16'h0001
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_SRC-1:0]       irq_in,
    eth_std_peripheral_irq_ctrl_if.slave bus,
    output logic                     irq
);

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_MASK     = 3'd1;
    localparam logic [2:0] REG_EDGE     = 3'd2;
    localparam logic [2:0] REG_ACTIVE   = 3'd3;
    localparam logic [2:0] REG_RAW      = 3'd4;
    localparam logic [2:0] REG_COALESCE = 3'd5;

    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] raw_d;
    logic [NUM_SRC-1:0] armed;
    logic [1:0]         sync_valid;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] wdata_src;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] mode_chg;
    logic [NUM_SRC-1:0] set_evt;
    logic [NUM_SRC-1:0] pend_masked;
    logic               act;
    logic               act_valid;
    logic [3:0]         act_id;
    logic               irq_nxt;
    logic [15:0]        rd_mux;
    logic [15:0]        coalesce_rd;
    logic               wr_en;

    function automatic logic [15:0] ext16(input logic [NUM_SRC-1:0] v);
        logic [15:0] r;
        r = '0;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    assign wr_en       = bus.chipselect & ~bus.write_n;
    assign wdata_src   = bus.writedata[NUM_SRC-1:0];
    assign w1c         = (wr_en && bus.address == REG_PENDING) ? wdata_src : '0;
    assign mode_chg    = (wr_en && bus.address == REG_EDGE) ? (edge_mode ^ wdata_src) : '0;
    assign set_evt     = armed & raw & ~raw_d;
    assign pend_masked = pending & mask;
    assign act         = |pend_masked;

    // Two-flop synchroniser; a source is only armed for edge detection once a genuine
    // low sample has passed through, so a line held high across reset never fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            raw        <= '0;
            raw_d      <= '0;
            sync_valid <= '0;
            armed      <= '0;
        end else begin
            sync1      <= irq_in;
            raw        <= sync1;
            raw_d      <= raw;
            sync_valid <= {sync_valid[0], 1'b1};
            armed      <= armed | (sync_valid[1] ? ~raw : '0);
        end
    end

    // Mode change clears the bit; edge bits: set beats W1C; level bits follow raw.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_chg[i])
                pending_nxt[i] = 1'b0;
            else if (edge_mode[i])
                pending_nxt[i] = set_evt[i] | (pending[i] & ~w1c[i]);
            else
                pending_nxt[i] = raw[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            mask      <= '0;
            edge_mode <= EDGE_RST[NUM_SRC-1:0];
        end else begin
            pending <= pending_nxt;
            if (wr_en && bus.address == REG_MASK)
                mask <= wdata_src;
            if (wr_en && bus.address == REG_EDGE)
                edge_mode <= wdata_src;
        end
    end

    always_comb begin
        act_valid = 1'b0;
        act_id    = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_masked[i]) begin
                act_valid = 1'b1;
                act_id    = 4'(i);
            end
        end
    end

`ifdef IRQ_CTRL_COALESCE_EN
    logic [15:0]        coalesce;
    logic [7:0]         evt_count;
    logic [7:0]         holdoff_timer;
    logic [NUM_SRC-1:0] new_evt;
    logic [4:0]         new_cnt;
    logic [8:0]         count_sum;

    // Only newly pending, masked edge sources count towards the threshold.
    assign new_evt = set_evt & edge_mode & mask & ~pending & ~mode_chg;

    always_comb begin
        new_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++)
            new_cnt = new_cnt + {4'd0, new_evt[i]};
    end

    assign count_sum   = {1'b0, (act ? evt_count : 8'd0)} + {4'd0, new_cnt};
    assign coalesce_rd = coalesce;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coalesce      <= '0;
            evt_count     <= '0;
            holdoff_timer <= '0;
        end else begin
            if (wr_en && bus.address == REG_COALESCE)
                coalesce <= bus.writedata;
            evt_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
            if (!act)
                holdoff_timer <= '0;
            else if (holdoff_timer != 8'hFF)
                holdoff_timer <= holdoff_timer + 8'd1;
        end
    end

    // A zero threshold disables coalescing entirely.
    always_comb begin
        if (coalesce[15:8] == 8'd0)
            irq_nxt = act;
        else
            irq_nxt = act && ((evt_count >= coalesce[15:8]) || (holdoff_timer >= coalesce[7:0]));
    end
`else
    logic unused_wdata;

    assign unused_wdata = ^bus.writedata;
    assign coalesce_rd  = '0;
    assign irq_nxt      = act;
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            REG_PENDING:  rd_mux = ext16(pending);
            REG_MASK:     rd_mux = ext16(mask);
            REG_EDGE:     rd_mux = ext16(edge_mode);
            REG_ACTIVE:   rd_mux = {act_valid, 11'd0, act_id};
            REG_RAW:      rd_mux = ext16(raw);
            REG_COALESCE: rd_mux = coalesce_rd;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rd_mux;
            irq          <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_eth_std_peripheral_irq_ctrl.sv
// Scoreboard bench for eth_std_peripheral_irq_ctrl: register reads queue their expected value and are checked on return.
module tb_eth_std_peripheral_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq_in;
    logic       irq;
    logic       rd_seen;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    eth_std_peripheral_irq_ctrl_if bus ();

    eth_std_peripheral_irq_ctrl #(
        .NUM_SRC  (8),
        .EDGE_RST (16'h0001)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_in  (irq_in),
        .bus     (bus.slave),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 16'h%04h, expected 16'h%04h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; the bus cycle is sampled on the following posedge.
    task automatic applyStimulus(input bit is_write, input logic [2:0] addr, input logic [15:0] data,
                                 input string tag = "write");
        bus.chipselect = 1'b1;
        bus.write_n    = ~is_write;
        bus.address    = addr;
        bus.writedata  = is_write ? data : 16'h0000;
        if (!is_write)
            sb_q.push_back('{tag, data});
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseIrq(input logic [7:0] bits);
        irq_in = irq_in | bits;
        @(negedge clk);
        irq_in = irq_in & ~bits;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_seen <= 1'b0;
        else
            rd_seen <= bus.chipselect && bus.write_n;
    end

    always @(negedge clk) begin
        if (rd_seen) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_underflow", 16'(sb_q.size()), 16'd1);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                checkOutput(e.tag, bus.readdata, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        irq_in         = 8'h00;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 16'h0000;
        waitCycles(3);
        checkOutput("rst_irq", 16'(irq), 16'h0000);
        checkOutput("rst_readdata", bus.readdata, 16'h0000);
        reset_n = 1'b1;
        waitCycles(4);

        applyStimulus(0, 3'd0, 16'h0000, "rst_pending");
        applyStimulus(0, 3'd1, 16'h0000, "rst_mask");
        applyStimulus(0, 3'd2, 16'h0001, "rst_edge");
        applyStimulus(0, 3'd3, 16'h0000, "rst_active");
        applyStimulus(0, 3'd5, 16'h0000, "rst_coalesce");

        // Single edge on bit 0: irq four clocks after the input pulse
        applyStimulus(1, 3'd1, 16'h0001);
        pulseIrq(8'h01);
        waitCycles(2);
        checkOutput("irq_latency_early", 16'(irq), 16'h0000);
        waitCycles(1);
        checkOutput("irq_latency", 16'(irq), 16'h0001);
        applyStimulus(0, 3'd3, 16'h8000, "active_bit0");
        applyStimulus(1, 3'd0, 16'h0001);
        checkOutput("irq_after_w1c_hold", 16'(irq), 16'h0001);
        waitCycles(1);
        checkOutput("irq_after_w1c_low", 16'(irq), 16'h0000);

        // Masking hides but keeps a pending bit
        pulseIrq(8'h01);
        waitCycles(3);
        checkOutput("irq_second_edge", 16'(irq), 16'h0001);
        applyStimulus(1, 3'd1, 16'h0000);
        waitCycles(1);
        checkOutput("mask_off_irq", 16'(irq), 16'h0000);
        applyStimulus(0, 3'd0, 16'h0001, "masked_pending_kept");
        applyStimulus(1, 3'd1, 16'h0001);
        waitCycles(1);
        checkOutput("mask_on_irq", 16'(irq), 16'h0001);

        // New edge lands on the same clock as its W1C
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        @(negedge clk);
        applyStimulus(1, 3'd0, 16'h0001);
        waitCycles(1);
        checkOutput("set_wins_irq", 16'(irq), 16'h0001);
        applyStimulus(0, 3'd0, 16'h0001, "set_wins_pending");
        applyStimulus(1, 3'd0, 16'h0001);
        waitCycles(1);

        // Priority encoding of ACTIVE
        applyStimulus(1, 3'd1, 16'h00FF);
        applyStimulus(1, 3'd2, 16'h0029);
        pulseIrq(8'h28);
        waitCycles(3);
        applyStimulus(0, 3'd3, 16'h8003, "active_lowest");
        applyStimulus(0, 3'd0, 16'h0028, "pending_3_5");
        applyStimulus(1, 3'd0, 16'h0008);
        applyStimulus(0, 3'd3, 16'h8005, "active_after_clr");
        applyStimulus(1, 3'd0, 16'h0020);
        applyStimulus(0, 3'd3, 16'h0000, "active_none");

        // Level source on bit 2 ignores W1C and tracks the input
        irq_in[2] = 1'b1;
        waitCycles(4);
        applyStimulus(0, 3'd4, 16'h0004, "raw_bit2");
        applyStimulus(1, 3'd0, 16'h0004);
        applyStimulus(0, 3'd0, 16'h0004, "level_w1c_ignored");
        checkOutput("level_irq", 16'(irq), 16'h0001);
        irq_in[2] = 1'b0;
        waitCycles(2);
        applyStimulus(0, 3'd0, 16'h0004, "level_hold");
        applyStimulus(0, 3'd0, 16'h0000, "level_drop");

        // Switching a high level source to edge mode clears it without an edge
        irq_in[4] = 1'b1;
        waitCycles(4);
        applyStimulus(0, 3'd0, 16'h0010, "level_bit4");
        applyStimulus(1, 3'd2, 16'h0039);
        waitCycles(3);
        applyStimulus(0, 3'd0, 16'h0000, "mode_chg_clear");
        irq_in[4] = 1'b0;
        waitCycles(3);

        applyStimulus(1, 3'd1, 16'hFFFF);
        applyStimulus(0, 3'd1, 16'h00FF, "mask_width");
        applyStimulus(0, 3'd6, 16'h0000, "reg6");
        applyStimulus(0, 3'd7, 16'h0000, "reg7");

`ifdef IRQ_CTRL_COALESCE_EN
        applyStimulus(1, 3'd2, 16'h0007);
        applyStimulus(1, 3'd1, 16'h0007);
        applyStimulus(1, 3'd5, 16'h0320);
        applyStimulus(0, 3'd5, 16'h0320, "coalesce_rw");
        waitCycles(1);
        // Two events stay below the threshold, so only the holdoff timer releases irq
        for (int k = 0; k <= 36; k++) begin
            irq_in = (k == 0) ? 8'h01 : ((k == 5) ? 8'h02 : 8'h00);
            if (k == 35) checkOutput("coal_below_holdoff", 16'(irq), 16'h0000);
            if (k == 36) checkOutput("coal_holdoff_expired", 16'(irq), 16'h0001);
            @(negedge clk);
        end
        applyStimulus(1, 3'd0, 16'h0007);
        waitCycles(2);
        checkOutput("coal_cleared", 16'(irq), 16'h0000);
        for (int k = 0; k <= 10; k++) begin
            irq_in = (k == 0) ? 8'h01 : ((k == 3) ? 8'h02 : ((k == 6) ? 8'h04 : 8'h00));
            if (k == 9)  checkOutput("coal_two_events", 16'(irq), 16'h0000);
            if (k == 10) checkOutput("coal_threshold", 16'(irq), 16'h0001);
            @(negedge clk);
        end
        applyStimulus(1, 3'd0, 16'h0007);
        applyStimulus(1, 3'd5, 16'h0000);
        waitCycles(2);
`else
        applyStimulus(1, 3'd5, 16'h0320);
        applyStimulus(0, 3'd5, 16'h0000, "coalesce_absent");
`endif

        // Asynchronous reset while irq is high with all sources pending
        applyStimulus(1, 3'd2, 16'h00FF);
        applyStimulus(1, 3'd1, 16'h00FF);
        pulseIrq(8'hFF);
        waitCycles(3);
        applyStimulus(0, 3'd0, 16'h00FF, "pending_all");
        waitCycles(1);
        checkOutput("irq_before_reset", 16'(irq), 16'h0001);
        #2;
        reset_n   = 1'b0;
        irq_in[0] = 1'b1;
        #1;
        checkOutput("async_rst_irq", 16'(irq), 16'h0000);
        checkOutput("async_rst_readdata", bus.readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(0, 3'd1, 16'h0000, "post_rst_mask");
        applyStimulus(0, 3'd2, 16'h0001, "post_rst_edge");
        waitCycles(6);
        applyStimulus(0, 3'd0, 16'h0000, "no_edge_after_reset");
        irq_in[0] = 1'b0;
        waitCycles(3);
        irq_in[0] = 1'b1;
        waitCycles(4);
        applyStimulus(0, 3'd0, 16'h0001, "edge_after_rearm");
        irq_in[0] = 1'b0;

        waitCycles(2);
        checkOutput("sb_drain", 16'(sb_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
